// File: rtl/syn_fifo_gen2.sv
// syn_fifo_gen2 -- single-clock FIFO with any DEPTH >= 2 (not only powers of two),
// registered occupancy count, threshold flags and sticky error flags.
//
// Optional feature macro: FIFO_FWFT_EN
//   undefined : an accepted read loads rdata at the clock edge and pulses rd_valid
//   defined   : first-word-fall-through; rdata shows the head word whenever the FIFO
//               is non-empty, rd_valid = (count > 0), an accepted read pops at the edge
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   wr_en, wdata      : write request and data
//   rd_en             : read request
//   clr_err           : synchronous clear of overflow/underflow
//   rdata, rd_valid   : read data and its qualifier
//   full, empty       : count == DEPTH / count == 0
//   almost_full/empty : count >= AF_LEVEL / count <= AE_LEVEL
//   count             : occupancy 0..DEPTH
//   overflow          : sticky, a write was rejected
//   underflow         : sticky, a read was rejected
module syn_fifo_gen2 #(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 16,
  parameter  int AF_LEVEL  = 12,
  parameter  int AE_LEVEL  = 4,
  localparam int PTR_WIDTH = $clog2(DEPTH),
  localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 rd_en,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     rdata,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AF_CNT   = CNT_WIDTH'(AF_LEVEL);
  localparam logic [CNT_WIDTH-1:0] AE_CNT   = CNT_WIDTH'(AE_LEVEL);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [PTR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_overflow, r_underflow;
  logic                 w_rd_acc, w_wr_acc;

  // A read needs stored data; a write into a full FIFO is only legal when the
  // same-cycle read frees a slot. The read term never depends on the write, so
  // an empty FIFO with both requests takes only the write.
  assign w_rd_acc = rd_en && (r_count != '0);
  assign w_wr_acc = wr_en && ((r_count != FULL_CNT) || w_rd_acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      // Explicit wrap compare: DEPTH need not be a power of two.
      if (w_wr_acc) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A fresh error in the clear cycle wins over the clear.
      r_overflow  <= (r_overflow  & ~clr_err) | (wr_en & ~w_wr_acc);
      r_underflow <= (r_underflow & ~clr_err) | (rd_en & ~w_rd_acc);
    end
  end

  // Storage is deliberately not reset; the pointer/count reset discards it.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !rst) r_mem[r_wr_ptr] <= wdata;
  end

`ifdef FIFO_FWFT_EN
  // Head word falls through; forced to zero while empty so reset shows rdata = 0.
  assign rdata    = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign rd_valid = (r_count != '0);
`else
  logic [WIDTH-1:0] r_rdata;
  logic             r_rd_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_rd_acc) r_rdata <= r_mem[r_rd_ptr];
      r_rd_valid <= w_rd_acc;
    end
  end

  assign rdata    = r_rdata;
  assign rd_valid = r_rd_valid;
`endif

  assign count        = r_count;
  assign full         = (r_count == FULL_CNT);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= AF_CNT);
  assign almost_empty = (r_count <= AE_CNT);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
